// File: rtl/nic_pkg.sv
// Shared NIC definitions: PE register addresses, status-register field layout
// and the position of the virtual-channel bit inside a packet.
package nic_pkg;

  typedef enum logic [1:0] {
    ADDR_IN_DATA  = 2'b00,
    ADDR_IN_STAT  = 2'b01,
    ADDR_OUT_DATA = 2'b10,
    ADDR_OUT_STAT = 2'b11
  } nic_addr_e;

  localparam int unsigned VC_BIT = 0;

  // Status bits in the upper nibble of the 64-bit status word
  localparam int unsigned STAT_ANY_FULL_BIT = 63;
  localparam int unsigned STAT_IN_VALID_BIT = 63;
  localparam int unsigned STAT_VC1_FULL_BIT = 62;
  localparam int unsigned STAT_VC0_FULL_BIT = 61;
  localparam int unsigned STAT_OVF_BIT      = 60;

  // Count fields
  localparam int unsigned IN_CNT_LSB  = 0;
  localparam int unsigned IN_CNT_W    = 32;
  localparam int unsigned VC0_CNT_LSB = 0;
  localparam int unsigned VC1_CNT_LSB = 16;
  localparam int unsigned VC_CNT_W    = 16;

endpackage

// File: rtl/nic_vc_fifo_if.sv
// NIC bus bundle: router handshake (si/ri in, so/ro out, polarity) plus the
// PE register port. slave = NIC side, master = router/PE side.
interface nic_vc_fifo_if #(
  parameter int unsigned PACKET_SIZE = 64
);
  logic                   net_si;
  logic                   net_ri;
  logic [PACKET_SIZE-1:0] net_di;
  logic                   net_so;
  logic                   net_ro;
  logic [PACKET_SIZE-1:0] net_do;
  logic                   net_polarity;
  logic [1:0]             addr;
  logic [PACKET_SIZE-1:0] d_in;
  logic [PACKET_SIZE-1:0] d_out;
  logic                   nicEn;
  logic                   nicEnWr;

  modport slave (
    input  net_si, net_di, net_ro, net_polarity, addr, d_in, nicEn, nicEnWr,
    output net_ri, net_so, net_do, d_out
  );

  modport master (
    output net_si, net_di, net_ro, net_polarity, addr, d_in, nicEn, nicEnWr,
    input  net_ri, net_so, net_do, d_out
  );
endinterface

// File: rtl/nic_sync_fifo.sv
// Synchronous FIFO with wrap-safe pointers for any DEPTH >= 2.
// Ports: clk, reset (sync active-low), push/push_data, pop, full_c, empty_c,
// count (registered occupancy), head_c (entry at read pointer).
// Push is judged against pre-edge full, so push at full is dropped even with a pop.
module nic_sync_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage; contents are don't-care while pointers are reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/nic_vc_fifo.sv
// NIC between PE and ring router: input FIFO from the router, two per-VC
// output FIFOs written by the PE, polarity-matched output arbitration.
// Ports: clk, reset (sync active-low), bus (nic_vc_fifo_if.slave) carrying
// net_si/ri/di, net_so/ro/do, net_polarity, addr, d_in, d_out, nicEn, nicEnWr.
module nic_vc_fifo
  import nic_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = 64,
  parameter int unsigned IN_DEPTH    = 4,
  parameter int unsigned OUT_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  nic_vc_fifo_if.slave   bus
);
  localparam int unsigned IN_CW  = $clog2(IN_DEPTH + 1);
  localparam int unsigned OUT_CW = $clog2(OUT_DEPTH + 1);

  logic                   in_full, in_empty, in_push, in_pop;
  logic [IN_CW-1:0]       in_count;
  logic [PACKET_SIZE-1:0] in_head;

  logic                   vc0_full, vc0_empty, vc0_push, vc0_pop;
  logic                   vc1_full, vc1_empty, vc1_push, vc1_pop;
  logic [OUT_CW-1:0]      vc0_count, vc1_count;
  logic [PACKET_SIZE-1:0] vc0_head, vc1_head;

  logic pe_rd, pe_wr, wr_vc, ovf_set, sel, send_c;
  logic overflow;

  assign pe_rd = bus.nicEn && !bus.nicEnWr;
  assign pe_wr = bus.nicEn && bus.nicEnWr && (bus.addr == ADDR_OUT_DATA);
  assign wr_vc = bus.d_in[VC_BIT];

  // Router -> input FIFO; PE data read pops
  assign bus.net_ri = !in_full;
  assign in_push    = bus.net_si && !in_full;
  assign in_pop     = pe_rd && (bus.addr == ADDR_IN_DATA) && !in_empty;

  // PE write steered by the packet's own VC bit
  assign vc0_push = pe_wr && !wr_vc;
  assign vc1_push = pe_wr && wr_vc;
  assign ovf_set  = pe_wr && (wr_vc ? vc1_full : vc0_full);

  // Only the VC matching this edge's polarity may send
  assign sel     = bus.net_polarity;
  assign send_c  = bus.net_ro && (sel ? !vc1_empty : !vc0_empty);
  assign vc0_pop = send_c && !sel;
  assign vc1_pop = send_c && sel;

  nic_sync_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .push(in_push), .push_data(bus.net_di),
    .pop(in_pop), .full_c(in_full), .empty_c(in_empty), .count(in_count),
    .head_c(in_head)
  );

  nic_sync_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(OUT_DEPTH)) u_vc0_fifo (
    .clk(clk), .reset(reset), .push(vc0_push), .push_data(bus.d_in),
    .pop(vc0_pop), .full_c(vc0_full), .empty_c(vc0_empty), .count(vc0_count),
    .head_c(vc0_head)
  );

  nic_sync_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(OUT_DEPTH)) u_vc1_fifo (
    .clk(clk), .reset(reset), .push(vc1_push), .push_data(bus.d_in),
    .pop(vc1_pop), .full_c(vc1_full), .empty_c(vc1_empty), .count(vc1_count),
    .head_c(vc1_head)
  );

  // Registered router output and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.net_so <= 1'b0;
      bus.net_do <= '0;
      overflow   <= 1'b0;
    end else begin
      bus.net_so <= send_c;
      if (send_c)  bus.net_do <= sel ? vc1_head : vc0_head;
      if (ovf_set) overflow   <= 1'b1;
    end
  end

  // PE read mux (combinational by design)
  always_comb begin
    bus.d_out = '0;
    if (pe_rd) begin
      unique case (bus.addr)
        ADDR_IN_DATA: bus.d_out = in_empty ? '0 : in_head;
        ADDR_IN_STAT: begin
          bus.d_out[STAT_IN_VALID_BIT]         = !in_empty;
          bus.d_out[IN_CNT_LSB +: IN_CNT_W]    = IN_CNT_W'(in_count);
        end
        ADDR_OUT_STAT: begin
          bus.d_out[STAT_ANY_FULL_BIT]         = vc0_full || vc1_full;
          bus.d_out[STAT_VC1_FULL_BIT]         = vc1_full;
          bus.d_out[STAT_VC0_FULL_BIT]         = vc0_full;
          bus.d_out[STAT_OVF_BIT]              = overflow;
          bus.d_out[VC0_CNT_LSB +: VC_CNT_W]   = VC_CNT_W'(vc0_count);
          bus.d_out[VC1_CNT_LSB +: VC_CNT_W]   = VC_CNT_W'(vc1_count);
        end
        default: bus.d_out = '0;
      endcase
    end
  end
endmodule
